// File: rtl/pong_pkg.sv
// Shared constants for the pong input stage: default timing parameters and the
// speed-level width, ceiling and saturating increment.
package pong_pkg;

    localparam int DEB_CYCLES_DEF = 500_000;
    localparam int TICK_BASE_DEF  = 25_000_000;
    localparam int TICK_STEP_DEF  = 2_500_000;
    localparam int TICK_MIN_DEF   = 6_250_000;
    localparam int CNT_W_DEF      = 25;

    localparam int               SPD_W   = 3;
    localparam logic [SPD_W-1:0] SPD_MAX = 3'd7;

    function automatic logic [SPD_W-1:0] spd_inc(input logic [SPD_W-1:0] lvl);
        if (lvl == SPD_MAX) begin
            return SPD_MAX;
        end else begin
            return lvl + 3'd1;
        end
    endfunction

endpackage

// File: rtl/pong_debounce.sv
// One paddle button: two-flop synchroniser, stable-cycle counter and a one-cycle
// pulse on the edge where the debounced level is accepted as high.
module pong_debounce
    import pong_pkg::*;
#(
    parameter int DEB_CYCLES = DEB_CYCLES_DEF
) (
    input  logic clk,
    input  logic reset,
    input  logic raw,
    output logic rise
);

    localparam int              DW       = (DEB_CYCLES > 1) ? $clog2(DEB_CYCLES) : 1;
    localparam logic [DW-1:0]   CNT_LAST = DW'(DEB_CYCLES - 1);
    localparam logic [DW-1:0]   CNT_ONE  = DW'(1'b1);
    localparam logic [DW-1:0]   CNT_ZERO = {DW{1'b0}};

    logic          sync1_r;
    logic          sync2_r;
    logic          db_r;
    logic [DW-1:0] cnt_r;
    logic          accept_s;

    // Bring the asynchronous button into the clk domain.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sync1_r <= 1'b0;
            sync2_r <= 1'b0;
        end else begin
            sync1_r <= raw;
            sync2_r <= sync1_r;
        end
    end

    // A change is accepted once it has persisted for DEB_CYCLES consecutive edges.
    always_comb begin
        accept_s = 1'b0;
        if ((sync2_r != db_r) && (cnt_r == CNT_LAST)) begin
            accept_s = 1'b1;
        end else begin
            accept_s = 1'b0;
        end
    end

    // Stable counter; any return to the accepted level restarts the count.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            db_r  <= 1'b0;
            cnt_r <= CNT_ZERO;
        end else if (sync2_r == db_r) begin
            cnt_r <= CNT_ZERO;
        end else if (accept_s) begin
            db_r  <= sync2_r;
            cnt_r <= CNT_ZERO;
        end else begin
            cnt_r <= cnt_r + CNT_ONE;
        end
    end

    assign rise = accept_s & sync2_r;

endmodule

// File: rtl/pong_input_stage.sv
// Front end of the ping-pong game: debounced, latched paddle presses plus the
// game tick whose period shortens with each return and restores on a miss.
module pong_input_stage
    import pong_pkg::*;
#(
    parameter int DEB_CYCLES = DEB_CYCLES_DEF,
    parameter int TICK_BASE  = TICK_BASE_DEF,
    parameter int TICK_STEP  = TICK_STEP_DEF,
    parameter int TICK_MIN   = TICK_MIN_DEF,
    parameter int CNT_W      = CNT_W_DEF
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             btn0_raw,
    input  logic             btn1_raw,
    input  logic             run,
    input  logic             hit_ack,
    input  logic             miss,
    output logic             tick,
    output logic             p0_hit,
    output logic             p1_hit,
    output logic [SPD_W-1:0] speed_lvl
);

    localparam int               CW1     = CNT_W + 1;
    localparam logic [CNT_W-1:0] BASE_V  = CNT_W'(TICK_BASE);
    localparam logic [CNT_W-1:0] STEP_V  = CNT_W'(TICK_STEP);
    localparam logic [CNT_W-1:0] MIN_V   = CNT_W'(TICK_MIN);
    localparam logic [CNT_W-1:0] ONE_V   = CNT_W'(1'b1);
    localparam logic [CNT_W-1:0] ZERO_V  = {CNT_W{1'b0}};
    // Smallest period that can take a full step without dropping below the floor.
    localparam logic [CW1-1:0]   FLOOR_V = CW1'(TICK_MIN) + CW1'(TICK_STEP);

    logic             rise0_s;
    logic             rise1_s;
    logic [CNT_W-1:0] tick_cnt_r;
    logic [CNT_W-1:0] cur_period_r;
    logic [CNT_W-1:0] reload_s;
    logic [CNT_W-1:0] period_nxt_s;
    logic [SPD_W-1:0] speed_r;
    logic [SPD_W-1:0] speed_nxt_s;
    logic             tick_r;
    logic             p0_hit_r;
    logic             p1_hit_r;

    pong_debounce #(.DEB_CYCLES(DEB_CYCLES)) u_deb0 (
        .clk   (clk),
        .reset (reset),
        .raw   (btn0_raw),
        .rise  (rise0_s)
    );

    pong_debounce #(.DEB_CYCLES(DEB_CYCLES)) u_deb1 (
        .clk   (clk),
        .reset (reset),
        .raw   (btn1_raw),
        .rise  (rise1_s)
    );

    assign reload_s = cur_period_r - ONE_V;

    // Tick down-counter; the new period only applies at the next reload.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            tick_cnt_r <= BASE_V - ONE_V;
            tick_r     <= 1'b0;
        end else if (!run) begin
            tick_cnt_r <= reload_s;
            tick_r     <= 1'b0;
        end else if (tick_cnt_r == ZERO_V) begin
            tick_cnt_r <= reload_s;
            tick_r     <= 1'b1;
        end else begin
            tick_cnt_r <= tick_cnt_r - ONE_V;
            tick_r     <= 1'b0;
        end
    end

    // Next period and speed level; miss overrides hit_ack.
    always_comb begin
        period_nxt_s = cur_period_r;
        speed_nxt_s  = speed_r;
        if (miss) begin
            period_nxt_s = BASE_V;
            speed_nxt_s  = {SPD_W{1'b0}};
        end else if (hit_ack) begin
            if ({1'b0, cur_period_r} >= FLOOR_V) begin
                period_nxt_s = cur_period_r - STEP_V;
            end else begin
                period_nxt_s = MIN_V;
            end
            speed_nxt_s = spd_inc(speed_r);
        end else begin
            period_nxt_s = cur_period_r;
            speed_nxt_s  = speed_r;
        end
    end

    // Speed state registers.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cur_period_r <= BASE_V;
            speed_r      <= {SPD_W{1'b0}};
        end else begin
            cur_period_r <= period_nxt_s;
            speed_r      <= speed_nxt_s;
        end
    end

    // Press latches: consumed on the edge ending a tick cycle, a fresh press wins.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            p0_hit_r <= 1'b0;
            p1_hit_r <= 1'b0;
        end else begin
            if (rise0_s) begin
                p0_hit_r <= 1'b1;
            end else if (tick_r) begin
                p0_hit_r <= 1'b0;
            end else begin
                p0_hit_r <= p0_hit_r;
            end
            if (rise1_s) begin
                p1_hit_r <= 1'b1;
            end else if (tick_r) begin
                p1_hit_r <= 1'b0;
            end else begin
                p1_hit_r <= p1_hit_r;
            end
        end
    end

    assign tick      = tick_r;
    assign p0_hit    = p0_hit_r;
    assign p1_hit    = p1_hit_r;
    assign speed_lvl = speed_r;

endmodule

// File: tb/tb_pong_input_stage.sv
// Randomised-bounce scoreboard bench for pong_input_stage: a reference model predicts every
// output change and a monitor pops and compares each change the design produces.
module tb_pong_input_stage;

    localparam int DEB = 4;
    localparam int TB  = 20;
    localparam int TS  = 4;
    localparam int TM  = 8;

    logic       clk      = 1'b0;
    logic       reset    = 1'b1;
    logic       btn0_raw = 1'b0;
    logic       btn1_raw = 1'b0;
    logic       run      = 1'b1;
    logic       hit_ack  = 1'b0;
    logic       miss     = 1'b0;
    logic       tick;
    logic       p0_hit;
    logic       p1_hit;
    logic [2:0] speed_lvl;

    pong_input_stage #(
        .DEB_CYCLES (DEB),
        .TICK_BASE  (TB),
        .TICK_STEP  (TS),
        .TICK_MIN   (TM),
        .CNT_W      (5)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .btn0_raw  (btn0_raw),
        .btn1_raw  (btn1_raw),
        .run       (run),
        .hit_ack   (hit_ack),
        .miss      (miss),
        .tick      (tick),
        .p0_hit    (p0_hit),
        .p1_hit    (p1_hit),
        .speed_lvl (speed_lvl)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    int edge_n = 0;

    typedef struct {
        int         cyc;
        logic [5:0] vec;
    } ev_t;
    ev_t sb_q[$];

    // Reference model state, expressed as event times and plain arithmetic.
    int         m_next;
    int         m_period;
    int         m_spd;
    bit         m_tick, m_p0, m_p1, m_db0, m_db1;
    logic [7:0] h0, h1;
    logic [5:0] m_prev;

    // True when the DEB raw samples that reach the debouncer all differ from its level.
    function automatic bit window_flip(input logic [7:0] h, input bit db);
        bit flip = 1'b1;
        for (int i = 1; i <= DEB; i++) begin
            if (h[i] == db) flip = 1'b0;
        end
        return flip;
    endfunction

    task automatic model_reset();
        edge_n   = 0;
        m_next   = TB;
        m_period = TB;
        m_spd    = 0;
        m_tick   = 1'b0;
        m_p0     = 1'b0;
        m_p1     = 1'b0;
        m_db0    = 1'b0;
        m_db1    = 1'b0;
        h0       = 8'd0;
        h1       = 8'd0;
        m_prev   = 6'd0;
        sb_q.delete();
    endtask

    task automatic model_step();
        bit         prev_tick, r0, r1;
        logic [5:0] v;
        ev_t        e;
        edge_n++;
        prev_tick = m_tick;
        r0 = 1'b0;
        r1 = 1'b0;
        if (window_flip(h0, m_db0)) begin m_db0 = !m_db0; r0 = m_db0; end
        if (window_flip(h1, m_db1)) begin m_db1 = !m_db1; r1 = m_db1; end
        h0 = {h0[6:0], btn0_raw};
        h1 = {h1[6:0], btn1_raw};
        if (run) begin
            m_tick = (edge_n == m_next);
            if (m_tick) m_next = edge_n + m_period;
        end else begin
            m_tick = 1'b0;
            m_next = edge_n + m_period;
        end
        if (miss) begin
            m_period = TB;
            m_spd    = 0;
        end else if (hit_ack) begin
            m_period = (m_period - TS < TM) ? TM : m_period - TS;
            m_spd    = (m_spd >= 7) ? 7 : m_spd + 1;
        end
        m_p0 = r0 ? 1'b1 : (prev_tick ? 1'b0 : m_p0);
        m_p1 = r1 ? 1'b1 : (prev_tick ? 1'b0 : m_p1);
        v = {m_tick, m_p0, m_p1, 3'(m_spd)};
        if (v != m_prev) begin
            e.cyc = edge_n;
            e.vec = v;
            sb_q.push_back(e);
            m_prev = v;
        end
    endtask

    initial begin
        model_reset();
        forever begin
            @(posedge clk or posedge reset);
            if (reset) model_reset();
            else       model_step();
        end
    end

    // Monitor: every change of the DUT output vector must match the next predicted change.
    initial begin
        logic [5:0] dut_prev = 6'd0;
        logic [5:0] cur;
        ev_t        e;
        forever begin
            @(negedge clk);
            if (reset) begin
                dut_prev = 6'd0;
            end else begin
                cur = {tick, p0_hit, p1_hit, speed_lvl};
                if (cur !== dut_prev) begin
                    checks++;
                    if (sb_q.size() == 0) begin
                        errors++;
                        $display("FAIL sb_unexpected: cyc %0d got vec %b, required no change", edge_n, cur);
                    end else begin
                        e = sb_q.pop_front();
                        if (e.cyc != edge_n || e.vec !== cur) begin
                            errors++;
                            $display("FAIL sb_event: got cyc %0d vec %b, required cyc %0d vec %b",
                                     edge_n, cur, e.cyc, e.vec);
                        end
                    end
                    dut_prev = cur;
                end
            end
        end
    end

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d, required %0d", name, act, exp);
        end
    endtask

    task automatic cycles(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic wait_tick();
        bit seen = 1'b0;
        for (int i = 0; i < 60 && !seen; i++) begin
            @(negedge clk);
            seen = tick;
        end
        if (!seen) begin
            checks++;
            errors++;
            $display("FAIL tick_timeout: got no tick in 60 cycles at cyc %0d, required a tick", edge_n);
        end
    endtask

    task automatic pulse_hit();
        hit_ack = 1'b1;
        @(negedge clk);
        hit_ack = 1'b0;
    endtask

    initial begin
        int r, t0, tt;
        bit found;

        cycles(3);
        check("rst_tick", tick, 0);
        check("rst_p0", p0_hit, 0);
        check("rst_p1", p1_hit, 0);
        check("rst_speed", speed_lvl, 0);
        reset = 1'b0;

        // Idle: ticks every TB cycles, first on edge 20.
        wait_tick();
        check("first_tick", edge_n, 20);
        cycles(25);

        // Bouncing button, then a clean hold.
        for (int k = 0; k < 3; k++) begin
            btn0_raw = 1'b1; cycles(2);
            btn0_raw = 1'b0; cycles(2);
        end
        btn0_raw = 1'b1;
        r = edge_n;
        found = 1'b0;
        for (int i = 0; i < 20 && !found; i++) begin
            @(negedge clk);
            found = p0_hit;
        end
        check("p0_latency", edge_n - r, 6);
        cycles(40);
        btn0_raw = 1'b0;
        cycles(20);

        // Random-length bounces on both buttons; the model tracks every outcome.
        for (int k = 0; k < 30; k++) begin
            btn0_raw = 1'($urandom_range(0, 1));
            btn1_raw = 1'($urandom_range(0, 1));
            cycles(int'($urandom_range(1, 7)));
        end
        btn0_raw = 1'b0;
        btn1_raw = 1'b0;
        cycles(30);

        // Held press is latched once and consumed by the next tick.
        wait_tick();
        cycles(5);
        btn1_raw = 1'b1;
        cycles(60);
        btn1_raw = 1'b0;
        cycles(25);

        // Speed-up sequence down to the floor, then a miss restores the base period.
        for (int k = 0; k < 5; k++) begin
            wait_tick();
            cycles(2);
            pulse_hit();
        end
        check("speed_after_hits", speed_lvl, 5);
        wait_tick();
        t0 = edge_n;
        wait_tick();
        check("period_floor", edge_n - t0, 8);
        cycles(1);
        miss = 1'b1;
        cycles(1);
        miss = 1'b0;
        check("speed_after_miss", speed_lvl, 0);
        wait_tick();
        t0 = edge_n;
        wait_tick();
        check("period_restored", edge_n - t0, 20);

        // hit_ack and miss together: miss wins.
        pulse_hit();
        pulse_hit();
        wait_tick();
        cycles(2);
        hit_ack = 1'b1;
        miss    = 1'b1;
        cycles(1);
        hit_ack = 1'b0;
        miss    = 1'b0;
        check("hm_speed", speed_lvl, 0);
        wait_tick();
        t0 = edge_n;
        wait_tick();
        check("hm_period", edge_n - t0, 20);

        // A press landing on the tick-consume edge survives to the following tick.
        tt = m_next;
        for (int i = 0; i < 40 && edge_n < tt - 5; i++) @(negedge clk);
        btn0_raw = 1'b1;
        while (edge_n < tt + 1) @(negedge clk);
        check("p0_set_wins", p0_hit, 1);
        wait_tick();
        check("p0_kept_to_tick", p0_hit, 1);
        cycles(1);
        check("p0_consumed", p0_hit, 0);
        btn0_raw = 1'b0;
        cycles(10);

        // Asynchronous reset mid-count with a pending press and speed 3.
        for (int k = 0; k < 3; k++) begin
            wait_tick();
            cycles(2);
            pulse_hit();
        end
        wait_tick();
        btn1_raw = 1'b1;
        found = 1'b0;
        for (int i = 0; i < 12 && !found; i++) begin
            @(negedge clk);
            found = p1_hit;
        end
        check("pre_rst_p1", p1_hit, 1);
        check("pre_rst_speed", speed_lvl, 3);
        #1 reset = 1'b1;
        #1;
        check("arst_tick", tick, 0);
        check("arst_p0", p0_hit, 0);
        check("arst_p1", p1_hit, 0);
        check("arst_speed", speed_lvl, 0);
        btn1_raw = 1'b0;
        cycles(3);
        reset = 1'b0;
        wait_tick();
        check("tick_after_rst", edge_n, 20);
        cycles(5);
        check("sb_drained", sb_q.size(), 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
